ysyx_23060061_mem_arbiter: RTL
==============================

# ysyx_23060061_mem_arbiter

Two-master, one-slave AXI-Lite arbiter that shares the single memory port between the IFU (master 0) and the LSU (master 1). It sits between both fetch/load-store units and the memory/SRAM slave. It grants one whole transaction at a time: read = AR+R, write = AW+W+B. Tie-breaking is round-robin, and the arbiter holds the grant until the response handshake completes.

## Interface
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; wstrb width = DATA_W/8

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- m0_araddr/m0_arvalid in ADDR_W/1, m0_arready out 1, m0_rdata/m0_rresp/m0_rvalid out DATA_W/2/1, m0_rready in 1  master 0 (IFU) read channels
- m0_awaddr/m0_awvalid in ADDR_W/1, m0_awready out 1, m0_wdata/m0_wstrb/m0_wvalid in DATA_W/DATA_W/8/1, m0_wready out 1, m0_bresp/m0_bvalid out 2/1, m0_bready in 1  master 0 write channels
- m1_* in/out, same set and widths as m0_*  master 1 (LSU) read and write channels
- s_araddr/s_arvalid out ADDR_W/1, s_arready in 1, s_rdata/s_rresp/s_rvalid in DATA_W/2/1, s_rready out 1  slave read channels
- s_awaddr/s_awvalid out ADDR_W/1, s_awready in 1, s_wdata/s_wstrb/s_wvalid out, s_wready in 1, s_bresp/s_bvalid in 2/1, s_bready out 1  slave write channels
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle

## Operation
- States: IDLE, M0_RD, M0_WR, M1_RD, M1_WR. These are registered; `grant` is decoded from the state.
- Request definitions, sampled in IDLE only:
  - req_rd[i] = mi_arvalid
  - req_wr[i] = mi_awvalid
  - req[i] = req_rd[i] | req_wr[i]
- Master selection in IDLE:
  - Exactly one req[i]: grant master i.
  - Both requesting: grant the master not granted last. The `last` register resets to 1, so m0 wins the first tie.
- Within the chosen master: a read has priority over a write when both are requested. Go to Mi_RD if req_rd[i], else Mi_WR. Update `last` to i.
- Granted state, combinational routing:
  - Granted master's channel signals connect straight to the slave: addr, data, strb, valid forward; ready, resp, rdata return.
  - Only the channels of the granted direction are connected.
  - Every other master-side ready/valid output is 0.
  - Slave-side valid/ready outputs are 0 for the non-granted direction.
- Completion and return to IDLE:
  - Mi_RD returns to IDLE on the cycle after s_rvalid & mi_rready.
  - Mi_WR returns to IDLE on the cycle after s_bvalid & mi_bready.
  - AW and W are passed through independently; the slave may accept them in either order.
- Idle outputs: in IDLE, every valid/ready output on both sides is 0. Data, address and resp outputs are 0 whenever not routed.
- No address decoding, no response modification, no buffering. rresp/bresp pass through unchanged, error codes included.
- Masters must hold valid until handshake (AXI rule). A request withdrawn before its handshake is a protocol violation; the arbiter is not required to recover from it.

## Timing
- Reset (rst=0, async):
  - State = IDLE, last = 1, grant = 00.
  - All outputs 0 within the same cycle, with no clock needed.
- Reset mid-transaction:
  - The grant drops immediately and any in-flight slave response is discarded.
  - After rst=1, the arbiter restarts from IDLE.
- Arbitration latency: a request seen in IDLE at edge N gives the granted state from edge N+1. The first s_arvalid/s_awvalid is high in the cycle after N.
- Handshake timing: each channel handshake completes in the same cycle as the slave's ready; the arbiter adds no delay inside a transaction.
- Turnaround:
  - At least one IDLE cycle separates consecutive transactions.
  - Minimum read occupancy = 1 (arb) + AR + R cycles.
  - Back-to-back same master: IDLE → grant → … → IDLE → grant.
- Simultaneous events:
  - A new request arriving during a granted transaction waits.
  - A request arriving on the completion cycle is arbitrated in the following IDLE cycle.
  - Round-robin guarantees a waiting master the next grant, so there is no starvation.

## Test plan
- Reset: assert rst=0 mid-M1_WR with s_awvalid=1. Required: s_awvalid and m1_awready fall to 0 asynchronously, grant=00. After release with no requests, everything stays 0.
- Single read:
  - Stimulus: m0_araddr=0x8000_0000, slave ready at once, rdata=0x0000_0413.
  - Required: s_arvalid is high 1 cycle after m0_arvalid, m0_rdata=0x0000_0413 with m0_rvalid, grant=01, then IDLE.
- Tie: m0_arvalid and m1_arvalid both rise from reset. Required: m0 served first (grant=01), then m1 (grant=10). A second simultaneous tie is served m0 first again because last=1.
- LSU write:
  - Stimulus: m1_awaddr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF; slave takes W two cycles before AW.
  - Required: s_wdata/s_wstrb match, m1_bvalid/bresp=00 are forwarded, and m0_awready, m0_wready and m0_bvalid stay 0 throughout.
- Contention fairness: m0 re-requests continuously while m1 requests once. Required: m1 is granted immediately after m0's current transaction completes.
- Error pass-through: slave returns rresp=2'b10 to m1. Required: m1_rresp=2'b10 and m0_rvalid=0.

Source files
------------

// File: rtl/ysyx_23060061_mem_arbiter.sv
// ysyx_23060061_mem_arbiter: round-robin AXI-Lite arbiter sharing one slave port between IFU (m0) and LSU (m1)
// One whole transaction (AR+R or AW+W+B) is granted at a time; routing is purely combinational from the state.
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [1:0]          grant
);
    typedef enum logic [2:0] {IDLE, M0_RD, M0_WR, M1_RD, M1_WR} state_t;
    state_t state, state_nxt;
    logic last, pick1, any_req, rd0, rd1, wr0, wr1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) last <= pick1;
        end
    end
    // On a tie, last=1 means m1 was served most recently, so m0 goes next
    always_comb begin
        any_req   = m0_arvalid | m0_awvalid | m1_arvalid | m1_awvalid;
        pick1     = (m1_arvalid | m1_awvalid) & (!(m0_arvalid | m0_awvalid) | !last);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !any_req ? IDLE : pick1 ? (m1_arvalid ? M1_RD : M1_WR)
                                                         : (m0_arvalid ? M0_RD : M0_WR);
            M0_RD:   state_nxt = (s_rvalid && m0_rready) ? IDLE : M0_RD;
            M0_WR:   state_nxt = (s_bvalid && m0_bready) ? IDLE : M0_WR;
            M1_RD:   state_nxt = (s_rvalid && m1_rready) ? IDLE : M1_RD;
            M1_WR:   state_nxt = (s_bvalid && m1_bready) ? IDLE : M1_WR;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        rd0        = state == M0_RD;
        rd1        = state == M1_RD;
        wr0        = state == M0_WR;
        wr1        = state == M1_WR;
        grant      = {rd1 | wr1, rd0 | wr0};
        s_araddr   = rd0 ? m0_araddr  : rd1 ? m1_araddr  : '0;
        s_arvalid  = rd0 ? m0_arvalid : rd1 ? m1_arvalid : 1'b0;
        s_rready   = rd0 ? m0_rready  : rd1 ? m1_rready  : 1'b0;
        s_awaddr   = wr0 ? m0_awaddr  : wr1 ? m1_awaddr  : '0;
        s_awvalid  = wr0 ? m0_awvalid : wr1 ? m1_awvalid : 1'b0;
        s_wdata    = wr0 ? m0_wdata   : wr1 ? m1_wdata   : '0;
        s_wstrb    = wr0 ? m0_wstrb   : wr1 ? m1_wstrb   : '0;
        s_wvalid   = wr0 ? m0_wvalid  : wr1 ? m1_wvalid  : 1'b0;
        s_bready   = wr0 ? m0_bready  : wr1 ? m1_bready  : 1'b0;
        m0_arready = rd0 & s_arready;
        m0_rdata   = rd0 ? s_rdata : '0;
        m0_rresp   = rd0 ? s_rresp : 2'b00;
        m0_rvalid  = rd0 & s_rvalid;
        m0_awready = wr0 & s_awready;
        m0_wready  = wr0 & s_wready;
        m0_bresp   = wr0 ? s_bresp : 2'b00;
        m0_bvalid  = wr0 & s_bvalid;
        m1_arready = rd1 & s_arready;
        m1_rdata   = rd1 ? s_rdata : '0;
        m1_rresp   = rd1 ? s_rresp : 2'b00;
        m1_rvalid  = rd1 & s_rvalid;
        m1_awready = wr1 & s_awready;
        m1_wready  = wr1 & s_wready;
        m1_bresp   = wr1 ? s_bresp : 2'b00;
        m1_bvalid  = wr1 & s_bvalid;
    end
endmodule
